// File: rtl/spec_accumulator.sv
// Range-bin spectrum integrator: sums per-bin magnitudes over NUM_FRAMES frames
// in a local RAM, streams the integrated bins out, then pulses spec_acc_done.
module spec_accumulator #(
   parameter int NUM_BINS   = 32,
   parameter int BIN_W      = 5,
   parameter int DATA_W     = 16,
   parameter int ACC_W      = 24,
   parameter int NUM_FRAMES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mag_valid,
   input  logic [DATA_W-1:0] mag_in,
   input  logic [BIN_W-1:0]  bin_idx,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BIN_W-1:0]  out_bin,
   output logic [ACC_W-1:0]  out_data,
   output logic              spec_acc_done,
   output logic [7:0]        frame_cnt
);
   // RAM spans the full index range so every bin_idx value is a legal address.
   localparam int               DEPTH    = 1 << BIN_W;
   localparam logic [BIN_W:0]   BINS_L   = (BIN_W+1)'(NUM_BINS);
   localparam logic [BIN_W:0]   CNT_ONE  = (BIN_W+1)'(1);
   localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);
   localparam logic [7:0]       FRAMES_L = 8'(NUM_FRAMES);

   typedef enum logic [2:0] {
      CLEAR   = 3'd0,
      ACCUM   = 3'd1,
      DRAIN   = 3'd2,
      READOUT = 3'd3,
      DONE    = 3'd4
   } state_t;

   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [DATA_W-1:0] mag);
      logic [ACC_W:0] sum;
      sum = {1'b0, acc} + (ACC_W+1)'(mag);
      if (sum[ACC_W]) begin
         sat_add = {ACC_W{1'b1}};
      end else begin
         sat_add = sum[ACC_W-1:0];
      end
   endfunction

   logic [ACC_W-1:0]  mem_q [DEPTH];

   state_t            state_q, state_d;
   logic [BIN_W:0]    cnt_q, cnt_d;
   logic [7:0]        frame_cnt_q, frame_cnt_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [BIN_W-1:0]  out_bin_q, out_bin_d;
   logic [ACC_W-1:0]  out_data_q, out_data_d;
   logic              done_q, done_d;

   logic              s1_valid_q, s1_valid_d;
   logic [BIN_W-1:0]  s1_bin_q, s1_bin_d;
   logic [DATA_W-1:0] s1_mag_q, s1_mag_d;
   logic              s2_valid_q, s2_valid_d;
   logic [BIN_W-1:0]  s2_bin_q, s2_bin_d;
   logic [ACC_W-1:0]  s2_sum_q, s2_sum_d;

   logic              accept;
   logic              in_range;
   logic [ACC_W-1:0]  operand;
   logic              mem_we;
   logic [BIN_W-1:0]  mem_waddr;
   logic [ACC_W-1:0]  mem_wdata;

   // Read-modify-write datapath; stage 2 has not written yet, so forward it.
   always_comb begin
      accept     = in_ready_q & mag_valid;
      in_range   = ({1'b0, bin_idx} < BINS_L);
      s1_valid_d = accept & in_range;
      s1_bin_d   = bin_idx;
      s1_mag_d   = mag_in;
      if (s2_valid_q && (s2_bin_q == s1_bin_q)) begin
         operand = s2_sum_q;
      end else begin
         operand = mem_q[s1_bin_q];
      end
      s2_valid_d = s1_valid_q;
      s2_bin_d   = s1_bin_q;
      s2_sum_d   = sat_add(operand, s1_mag_q);
   end

   // Control FSM, readout sequencing and the single RAM write port mux.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      frame_cnt_d = frame_cnt_q;
      out_valid_d = out_valid_q;
      out_bin_d   = out_bin_q;
      out_data_d  = out_data_q;
      mem_we      = 1'b0;
      mem_waddr   = s2_bin_q;
      mem_wdata   = s2_sum_q;
      case (state_q)
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q[BIN_W-1:0];
            mem_wdata = {ACC_W{1'b0}};
            if (cnt_q == (BINS_L - CNT_ONE)) begin
               state_d = ACCUM;
               cnt_d   = {(BIN_W+1){1'b0}};
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ACCUM: begin
            mem_we = s2_valid_q;
            if (accept && in_range && (bin_idx == LAST_BIN)) begin
               frame_cnt_d = frame_cnt_q + 8'd1;
               if ((frame_cnt_q + 8'd1) == FRAMES_L) begin
                  state_d = DRAIN;
               end else begin
                  state_d = ACCUM;
               end
            end else begin
               frame_cnt_d = frame_cnt_q;
            end
         end
         DRAIN: begin
            // Stage 2 writes this cycle, so the RAM is settled by READOUT entry.
            mem_we = s2_valid_q;
            if (!s1_valid_q) begin
               state_d = READOUT;
               cnt_d   = {(BIN_W+1){1'b0}};
            end else begin
               state_d = DRAIN;
            end
         end
         READOUT: begin
            if (out_valid_q && out_ready) begin
               mem_we    = 1'b1;
               mem_waddr = out_bin_q;
               mem_wdata = {ACC_W{1'b0}};
            end else begin
               mem_we = 1'b0;
            end
            if (!out_valid_q || out_ready) begin
               if (cnt_q < BINS_L) begin
                  out_valid_d = 1'b1;
                  out_bin_d   = cnt_q[BIN_W-1:0];
                  out_data_d  = mem_q[cnt_q[BIN_W-1:0]];
                  cnt_d       = cnt_q + CNT_ONE;
               end else begin
                  out_valid_d = 1'b0;
                  state_d     = DONE;
                  frame_cnt_d = 8'd0;
               end
            end else begin
               out_valid_d = out_valid_q;
            end
         end
         DONE: begin
            state_d     = ACCUM;
            frame_cnt_d = 8'd0;
         end
         default: begin
            state_d = CLEAR;
            cnt_d   = {(BIN_W+1){1'b0}};
         end
      endcase
      in_ready_d = (state_d == ACCUM);
      done_d     = (state_d == DONE);
   end

   // Control and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= CLEAR;
         cnt_q       <= {(BIN_W+1){1'b0}};
         frame_cnt_q <= 8'd0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_bin_q   <= {BIN_W{1'b0}};
         out_data_q  <= {ACC_W{1'b0}};
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         frame_cnt_q <= frame_cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_bin_q   <= out_bin_d;
         out_data_q  <= out_data_d;
         done_q      <= done_d;
      end
   end

   // Read-modify-write pipeline registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_bin_q   <= {BIN_W{1'b0}};
         s1_mag_q   <= {DATA_W{1'b0}};
         s2_valid_q <= 1'b0;
         s2_bin_q   <= {BIN_W{1'b0}};
         s2_sum_q   <= {ACC_W{1'b0}};
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_bin_q   <= s1_bin_d;
         s1_mag_q   <= s1_mag_d;
         s2_valid_q <= s2_valid_d;
         s2_bin_q   <= s2_bin_d;
         s2_sum_q   <= s2_sum_d;
      end
   end

   // Accumulation RAM; contents are initialised by the CLEAR state, not reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign in_ready      = in_ready_q;
   assign out_valid     = out_valid_q;
   assign out_bin       = out_bin_q;
   assign out_data      = out_data_q;
   assign spec_acc_done = done_q;
   assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_spec_accumulator.sv
// Directed bench for spec_accumulator: 4 bins, 2 frames per period, 16-bit accumulators.
module tb_spec_accumulator;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mag_valid = 1'b0;
   logic [15:0] mag_in = 16'd0;
   logic [2:0]  bin_idx = 3'd0;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [2:0]  out_bin;
   logic [15:0] out_data;
   logic        spec_acc_done;
   logic [7:0]  frame_cnt;

   int checks = 0;
   int errors = 0;

   spec_accumulator #(
      .NUM_BINS(4), .BIN_W(3), .DATA_W(16), .ACC_W(16), .NUM_FRAMES(2)
   ) dut (
      .clk(clk), .rst(rst), .mag_valid(mag_valid), .mag_in(mag_in),
      .bin_idx(bin_idx), .in_ready(in_ready), .out_valid(out_valid),
      .out_ready(out_ready), .out_bin(out_bin), .out_data(out_data),
      .spec_acc_done(spec_acc_done), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   // Present one sample once in_ready is high; it is accepted at the next edge.
   task automatic send(input logic [2:0] b, input logic [15:0] m);
      int n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_wait: in_ready=%b required 1", in_ready);
      end
      mag_valid = 1'b1; bin_idx = b; mag_in = m;
      @(posedge clk); #1;
      mag_valid = 1'b0;
   endtask

   // Drain one period; stall selects the 1,0,0,1 out_ready pattern.
   task automatic readout(input string nm, input bit stall,
                          input logic [15:0] e0, e1, e2, e3);
      logic [15:0] exp_v [4];
      logic [2:0]  hb = 3'd0;
      logic [15:0] hd = 16'd0;
      bit          held = 1'b0;
      int          k = 0;
      int          cyc = 0;
      exp_v = '{e0, e1, e2, e3};
      while (k < 4 && cyc < 80) begin
         if (held) begin
            checks++;
            if (out_valid !== 1'b1 || out_bin !== hb || out_data !== hd) begin
               errors++;
               $display("FAIL %s stall_hold: valid=%b bin=%0d data=%h required 1 %0d %h",
                        nm, out_valid, out_bin, out_data, hb, hd);
            end
         end
         out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         if (out_valid === 1'b1) begin
            checks++;
            if (in_ready !== 1'b0 || spec_acc_done !== 1'b0) begin
               errors++;
               $display("FAIL %s readout_flags: in_ready=%b done=%b required 0 0",
                        nm, in_ready, spec_acc_done);
            end
            if (out_ready) begin
               checks++;
               if (out_bin !== 3'(k) || out_data !== exp_v[k]) begin
                  errors++;
                  $display("FAIL %s beat%0d: bin=%0d data=%h required %0d %h",
                           nm, k, out_bin, out_data, k, exp_v[k]);
               end
               k++;
               held = 1'b0;
            end else begin
               held = 1'b1; hb = out_bin; hd = out_data;
            end
         end else begin
            held = 1'b0;
         end
         @(posedge clk); #1; cyc++;
      end
      checks++;
      if (k != 4) begin
         errors++;
         $display("FAIL %s timeout: beats=%0d required 4", nm, k);
      end
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || spec_acc_done !== 1'b1 || frame_cnt !== 8'd0) begin
         errors++;
         $display("FAIL %s done_pulse: valid=%b done=%b frame_cnt=%0d required 0 1 0",
                  nm, out_valid, spec_acc_done, frame_cnt);
      end
      @(posedge clk); #1;
      checks++;
      if (spec_acc_done !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s after_done: done=%b in_ready=%b required 0 1",
                  nm, spec_acc_done, in_ready);
      end
      mag_valid = 1'b0;
   endtask

   task automatic test_reset();
      int n = 0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_bin !== 3'd0 ||
          out_data !== 16'd0 || spec_acc_done !== 1'b0 || frame_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_values: rdy=%b vld=%b bin=%0d data=%h done=%b fc=%0d required all 0",
                  in_ready, out_valid, out_bin, out_data, spec_acc_done, frame_cnt);
      end
      rst = 1'b0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (n != 4) begin
         errors++;
         $display("FAIL clear_len: cycles=%0d required 4", n);
      end
   endtask

   task automatic test_basic();
      for (int f = 0; f < 2; f++) begin
         for (int b = 0; b < 4; b++) send(3'(b), 16'(b + 1));
         checks++;
         if (frame_cnt !== 8'(f + 1) || in_ready !== (f == 0)) begin
            errors++;
            $display("FAIL basic_frame%0d: frame_cnt=%0d in_ready=%b required %0d %b",
                     f, frame_cnt, in_ready, f + 1, f == 0);
         end
      end
      readout("basic", 1'b0, 16'd2, 16'd4, 16'd6, 16'd8);
   endtask

   task automatic test_hazard();
      for (int i = 0; i < 6; i++) send(3'd1, 16'd5);
      send(3'd0, 16'd0); send(3'd2, 16'd0); send(3'd3, 16'd0);
      send(3'd2, 16'd1); send(3'd0, 16'd0); send(3'd2, 16'd1);
      send(3'd1, 16'd0); send(3'd3, 16'd0);
      readout("hazard", 1'b0, 16'd0, 16'd30, 16'd2, 16'd0);
   endtask

   task automatic test_saturation();
      send(3'd0, 16'hFFFF); send(3'd1, 16'h8000); send(3'd2, 16'h0001); send(3'd3, 16'h0000);
      send(3'd0, 16'hFFFF); send(3'd1, 16'h8000); send(3'd2, 16'h7FFF); send(3'd3, 16'h0001);
      readout("saturation", 1'b0, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h0001);
   endtask

   task automatic test_backpressure();
      send(3'd2, 16'd30); send(3'd0, 16'd10); send(3'd1, 16'd20); send(3'd3, 16'd40);
      send(3'd1, 16'd1); send(3'd2, 16'd1); send(3'd0, 16'd1); send(3'd3, 16'd1);
      readout("backpressure", 1'b1, 16'd11, 16'd21, 16'd31, 16'd41);
   endtask

   task automatic test_two_periods();
      for (int f = 0; f < 2; f++)
         for (int b = 0; b < 4; b++) send(3'(b), 16'd100);
      mag_valid = 1'b1; bin_idx = 3'd0; mag_in = 16'd500;
      readout("period_a", 1'b0, 16'd200, 16'd200, 16'd200, 16'd200);
      for (int f = 0; f < 2; f++)
         for (int b = 0; b < 4; b++) send(3'(b), 16'd3);
      readout("period_b", 1'b0, 16'd6, 16'd6, 16'd6, 16'd6);
   endtask

   task automatic test_reset_mid();
      int n = 0;
      for (int b = 0; b < 4; b++) send(3'(b), 16'd50);
      checks++;
      if (frame_cnt !== 8'd1) begin
         errors++;
         $display("FAIL mid_frame_cnt: frame_cnt=%0d required 1", frame_cnt);
      end
      send(3'd0, 16'd77);
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_bin !== 3'd0 ||
          out_data !== 16'd0 || spec_acc_done !== 1'b0 || frame_cnt !== 8'd0) begin
         errors++;
         $display("FAIL mid_reset_values: rdy=%b vld=%b bin=%0d data=%h done=%b fc=%0d required all 0",
                  in_ready, out_valid, out_bin, out_data, spec_acc_done, frame_cnt);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (n != 4) begin
         errors++;
         $display("FAIL mid_clear_len: cycles=%0d required 4", n);
      end
      send(3'd0, 16'd1); send(3'd7, 16'd9);
      checks++;
      if (frame_cnt !== 8'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL out_of_range: frame_cnt=%0d in_ready=%b required 0 1", frame_cnt, in_ready);
      end
      send(3'd1, 16'd2); send(3'd2, 16'd3); send(3'd3, 16'd4);
      for (int b = 0; b < 4; b++) send(3'(b), 16'(b + 1));
      readout("after_reset", 1'b0, 16'd2, 16'd4, 16'd6, 16'd8);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hazard();
      test_saturation();
      test_backpressure();
      test_two_periods();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
